// File: rtl/pixel_engine_pkg.sv
// Shared widths, pixel/word types and the BPP-group reversal helper for the
// sprite pixel engine.
package pixel_engine_pkg;

  localparam int DEF_BPP          = 2;
  localparam int DEF_PIX_PER_WORD = 16;
  localparam int DEF_WORD_W       = DEF_BPP * DEF_PIX_PER_WORD;

  typedef logic [DEF_BPP-1:0]    pixel_t;
  typedef logic [DEF_WORD_W-1:0] word_t;

  localparam pixel_t TRANSPARENT = '0;

  // Pixel k of the result is pixel PIX_PER_WORD-1-k of the input.
  function automatic word_t flip_word(input word_t w);
    word_t r;
    r = '0;
    for (int i = 0; i < DEF_PIX_PER_WORD; i++) begin
      r[i*DEF_BPP +: DEF_BPP] = w[(DEF_PIX_PER_WORD-1-i)*DEF_BPP +: DEF_BPP];
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_channel.sv
// One sprite shifter: x-delay countdown, then PIX_PER_WORD pixels shifted out
// LSB-first. Exposes the current pixel and whether it is visible.
module sprite_channel
  import pixel_engine_pkg::*;
#(
  parameter int BPP          = DEF_BPP,
  parameter int PIX_PER_WORD = DEF_PIX_PER_WORD,
  parameter int XW           = 9
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic                        shift,
  input  logic [BPP*PIX_PER_WORD-1:0] data,
  input  logic [XW-1:0]               x,
  input  logic                        flip,
  input  logic                        pri,
  output logic                        visible,
  output logic [BPP-1:0]              pixel,
  output logic                        pri_out
);

  localparam int WORD_W = BPP * PIX_PER_WORD;
  localparam int RW     = $clog2(PIX_PER_WORD) + 1;

  logic [WORD_W-1:0] flipped;
  logic [WORD_W-1:0] pix_buf_q, pix_buf_d;
  logic [XW-1:0]     xcnt_q, xcnt_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic              active_q, active_d;
  logic              pri_q, pri_d;

  generate
    if (BPP == DEF_BPP && PIX_PER_WORD == DEF_PIX_PER_WORD) begin : g_pkg_flip
      assign flipped = flip_word(data);
    end else begin : g_gen_flip
      for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_grp
        assign flipped[gi*BPP +: BPP] = data[(PIX_PER_WORD-1-gi)*BPP +: BPP];
      end
    end
  endgenerate

  // A load in the same cycle as a shift takes the new word unshifted.
  always_comb begin
    pix_buf_d = pix_buf_q;
    xcnt_d    = xcnt_q;
    rem_d     = rem_q;
    active_d  = active_q;
    pri_d     = pri_q;
    if (load) begin
      pix_buf_d = flip ? flipped : data;
      xcnt_d    = x;
      rem_d     = RW'(PIX_PER_WORD);
      pri_d     = pri;
      active_d  = 1'b1;
    end else if (shift && active_q) begin
      if (xcnt_q != '0) begin
        xcnt_d = xcnt_q - XW'(1);
      end else if (rem_q != '0) begin
        pix_buf_d = pix_buf_q >> BPP;
        rem_d     = rem_q - RW'(1);
        if (rem_q == RW'(1)) active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_buf_q <= '0;
      xcnt_q    <= '0;
      rem_q     <= '0;
      active_q  <= 1'b0;
      pri_q     <= 1'b0;
    end else begin
      pix_buf_q <= pix_buf_d;
      xcnt_q    <= xcnt_d;
      rem_q     <= rem_d;
      active_q  <= active_d;
      pri_q     <= pri_d;
    end
  end

  assign pixel   = pix_buf_q[BPP-1:0];
  assign pri_out = pri_q;
  assign visible = active_q && (xcnt_q == '0) && (rem_q != '0) &&
                   (pix_buf_q[BPP-1:0] != BPP'(TRANSPARENT));

endmodule

// File: rtl/sprite_pixel_engine.sv
// Scanline pixel generator: NUM_SPRITES sprite shifters over a double-buffered,
// fine-x scrollable background. Optional sticky sprite-0 hit via SPRITE0_HIT_EN.
module sprite_pixel_engine
  import pixel_engine_pkg::*;
#(
  parameter int NUM_SPRITES  = 8,
  parameter int BPP          = DEF_BPP,
  parameter int PIX_PER_WORD = DEF_PIX_PER_WORD,
  parameter int XW           = 9,
  localparam int WORD_W      = BPP * PIX_PER_WORD,
  localparam int SW          = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int FW          = $clog2(PIX_PER_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic              pixel_en,
  input  logic              spr_load,
  input  logic [SW-1:0]     spr_sel,
  input  logic [WORD_W-1:0] spr_data,
  input  logic [XW-1:0]     spr_x,
  input  logic              spr_flip,
  input  logic              spr_pri,
  input  logic              bg_load,
  input  logic [WORD_W-1:0] bg_data,
  input  logic [FW-1:0]     fine_x,
`ifdef SPRITE0_HIT_EN
  input  logic              hit_clear,
  output logic              sprite0_hit,
`endif
  output logic              bg_need,
  output logic              pix_valid,
  output logic [BPP-1:0]    pix_color,
  output logic              pix_is_sprite,
  output logic [SW-1:0]     pix_sprite_id,
  output logic              bg_underrun
);

  localparam int CW = FW + 1;

  // line_start takes the cycle: no pixel is produced and nothing shifts.
  logic adv;
  assign adv = pixel_en && !line_start;

  logic [NUM_SPRITES-1:0] spr_vis;
  logic [NUM_SPRITES-1:0] spr_pri_w;
  logic [BPP-1:0]         spr_pix [NUM_SPRITES];

  generate
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_spr
      sprite_channel #(
        .BPP          (BPP),
        .PIX_PER_WORD (PIX_PER_WORD),
        .XW           (XW)
      ) u_chan (
        .clk     (clk),
        .reset   (reset),
        .load    (spr_load && (spr_sel == SW'(gi))),
        .shift   (adv),
        .data    (spr_data),
        .x       (spr_x),
        .flip    (spr_flip),
        .pri     (spr_pri),
        .visible (spr_vis[gi]),
        .pixel   (spr_pix[gi]),
        .pri_out (spr_pri_w[gi])
      );
    end
  endgenerate

  logic [WORD_W-1:0] bg_cur_q, bg_cur_d;
  logic [WORD_W-1:0] bg_next_q, bg_next_d;
  logic              bg_next_valid_q, bg_next_valid_d;
  logic [CW-1:0]     bg_cnt_q, bg_cnt_d;
  logic              bg_underrun_q, bg_underrun_d;
  logic              reload;

  always_comb begin
    bg_cur_d        = bg_cur_q;
    bg_next_d       = bg_next_q;
    bg_next_valid_d = bg_next_valid_q;
    bg_cnt_d        = bg_cnt_q;
    bg_underrun_d   = bg_underrun_q;
    reload          = 1'b0;
    if (line_start) begin
      bg_cur_d        = bg_next_q >> (fine_x * BPP);
      bg_cnt_d        = CW'(PIX_PER_WORD) - CW'(fine_x);
      bg_next_valid_d = 1'b0;
      bg_underrun_d   = 1'b0;
    end else if (adv && bg_cnt_q == CW'(1)) begin
      reload          = 1'b1;
      bg_cnt_d        = CW'(PIX_PER_WORD);
      bg_next_valid_d = 1'b0;
      if (bg_next_valid_q) begin
        bg_cur_d = bg_next_q;
        if (bg_load) begin
          bg_next_d       = bg_data;
          bg_next_valid_d = 1'b1;
        end
      end else if (bg_load) begin
        bg_cur_d = bg_data;
      end else begin
        bg_cur_d      = '0;
        bg_underrun_d = 1'b1;
      end
    end else if (adv && bg_cnt_q != '0) begin
      bg_cur_d = bg_cur_q >> BPP;
      bg_cnt_d = bg_cnt_q - CW'(1);
    end
    // A word loaded alongside line_start lands in the freshly emptied buffer.
    if (bg_load && !reload) begin
      bg_next_d       = bg_data;
      bg_next_valid_d = 1'b1;
    end
  end

  logic [BPP-1:0] bg_pix;
  assign bg_pix = bg_cur_q[BPP-1:0];

  logic           found;
  logic [SW-1:0]  win_id;
  logic [BPP-1:0] win_pix;
  logic           win_pri;

  always_comb begin
    found   = 1'b0;
    win_id  = '0;
    win_pix = '0;
    win_pri = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (!found && spr_vis[i]) begin
        found   = 1'b1;
        win_id  = SW'(i);
        win_pix = spr_pix[i];
        win_pri = spr_pri_w[i];
      end
    end
  end

  logic           pix_valid_q, pix_valid_d;
  logic [BPP-1:0] pix_color_q, pix_color_d;
  logic           pix_is_sprite_q, pix_is_sprite_d;
  logic [SW-1:0]  pix_sprite_id_q, pix_sprite_id_d;

  always_comb begin
    pix_valid_d     = adv;
    pix_color_d     = pix_color_q;
    pix_is_sprite_d = pix_is_sprite_q;
    pix_sprite_id_d = pix_sprite_id_q;
    if (adv) begin
      if (found && (!win_pri || bg_pix == BPP'(TRANSPARENT))) begin
        pix_color_d     = win_pix;
        pix_is_sprite_d = 1'b1;
        pix_sprite_id_d = win_id;
      end else begin
        pix_color_d     = bg_pix;
        pix_is_sprite_d = 1'b0;
        pix_sprite_id_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bg_cur_q        <= '0;
      bg_next_q       <= '0;
      bg_next_valid_q <= 1'b0;
      bg_cnt_q        <= '0;
      bg_underrun_q   <= 1'b0;
      pix_valid_q     <= 1'b0;
      pix_color_q     <= '0;
      pix_is_sprite_q <= 1'b0;
      pix_sprite_id_q <= '0;
    end else begin
      bg_cur_q        <= bg_cur_d;
      bg_next_q       <= bg_next_d;
      bg_next_valid_q <= bg_next_valid_d;
      bg_cnt_q        <= bg_cnt_d;
      bg_underrun_q   <= bg_underrun_d;
      pix_valid_q     <= pix_valid_d;
      pix_color_q     <= pix_color_d;
      pix_is_sprite_q <= pix_is_sprite_d;
      pix_sprite_id_q <= pix_sprite_id_d;
    end
  end

`ifdef SPRITE0_HIT_EN
  // Hit ignores priority: any overlap of sprite 0 with opaque background.
  logic hit_q, hit_d;
  always_comb begin
    hit_d = hit_q && !hit_clear;
    if (adv && spr_vis[0] && bg_pix != BPP'(TRANSPARENT)) hit_d = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) hit_q <= 1'b0;
    else       hit_q <= hit_d;
  end
  assign sprite0_hit = hit_q;
`endif

  assign bg_need       = !bg_next_valid_q;
  assign bg_underrun   = bg_underrun_q;
  assign pix_valid     = pix_valid_q;
  assign pix_color     = pix_color_q;
  assign pix_is_sprite = pix_is_sprite_q;
  assign pix_sprite_id = pix_sprite_id_q;

endmodule

// File: doc/sprite_pixel_engine.md
Name: sprite_pixel_engine

Overview:
- Per-scanline pixel generator for the tile/sprite video path.
- Holds NUM_SPRITES sprite shifters and one double-buffered background shifter.
- Each sprite has an x-delay, horizontal flip and a priority bit; the background supports fine-x scroll.
- Composites one colour index per pixel_en strobe for the palette stage.

Parameters:
NUM_SPRITES, 8, sprite channels (1..16)
BPP, 2, bits per pixel index
PIX_PER_WORD, 16, pixels per loaded word; WORD_W = BPP*PIX_PER_WORD
XW, 9, sprite x-delay width
SW = $clog2(NUM_SPRITES); FW = $clog2(PIX_PER_WORD) (derived localparams)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high; clock clk
line_start  in  1  scanline start pulse
pixel_en  in  1  advance one pixel
spr_load  in  1  load sprite channel spr_sel
spr_sel  in  SW  channel index
spr_data  in  WORD_W  pixel word, pixel 0 in bits [BPP-1:0]
spr_x  in  XW  pixel_en strobes to wait before the first sprite pixel
spr_flip  in  1  reverse pixel order
spr_pri  in  1  1 = behind non-zero background
bg_load  in  1  write next background word
bg_data  in  WORD_W  background word
fine_x  in  FW  pixels skipped in the first background word of a line
bg_need  out  1  next background word wanted (= !bg_next_valid)
pix_valid  out  1  output pixel valid
pix_color  out  BPP  composited index
pix_is_sprite  out  1  pixel came from a sprite
pix_sprite_id  out  SW  winning sprite (0 when pix_is_sprite=0)
bg_underrun  out  1  sticky; cleared by line_start

Behaviour:
- Reset: all shifters, counters, active flags, bg_next_valid and outputs are 0. Reset dominates every other input.
- Sprite load (spr_load, channel i):
  - buf <= spr_data, pixel-reversed in BPP groups when spr_flip=1.
  - xcnt <= spr_x; rem <= PIX_PER_WORD; pri <= spr_pri; active <= 1.
  - Reloading an active channel restarts it.
  - Load beats pixel_en for that channel in the same cycle: no shift that cycle.
- Sprite shift, per pixel_en:
  - If active and xcnt!=0: decrement xcnt.
  - Else if rem!=0: shift buf right by BPP, rem--.
  - When rem reaches 0: active <= 0.
  - A sprite is visible when active, xcnt==0, rem!=0 and buf[BPP-1:0]!=0; index 0 is transparent.
- Background:
  - bg_load writes bg_next and sets bg_next_valid.
  - line_start: bg_cur <= bg_next >> (fine_x*BPP); bg_cnt <= PIX_PER_WORD-fine_x; bg_next_valid <= 0; bg_underrun <= 0.
  - Each pixel_en: shift bg_cur by BPP, bg_cnt--.
  - When bg_cnt==1 on pixel_en, reload:
    - bg_cur <= bg_next, bg_cnt <= PIX_PER_WORD, bg_next_valid <= 0.
    - If bg_load occurs in the same cycle: with valid=0, bg_data bypasses straight into bg_cur; with valid=1, bg_next <= bg_data and valid stays 1.
    - Reload with no valid word: bg_cur <= 0 and bg_underrun <= 1.
  - bg_load while valid with no reload overwrites bg_next.
- Compositing:
  - Samples the current pixel (before the shift); outputs are registered; pix_valid <= pixel_en (latency 1).
  - The lowest-index visible sprite wins first; its pri bit is then applied.
  - Sprite is shown if pri=0 or the bg pixel is 0; otherwise the bg pixel is shown.
  - pix_color, pix_is_sprite and pix_sprite_id hold while pix_valid=0.
- line_start with pixel_en in the same cycle: line_start wins, no shift, pix_valid=0.
- Sprite channels are not cleared by line_start. Software loads sprites during hblank, before line_start.

Optional Feature:
- Macro SPRITE0_HIT_EN.
- Defined: adds output sprite0_hit (1 bit), sticky. It is set on any pixel_en where sprite 0 is visible and the bg pixel is non-zero, regardless of priority. It is cleared only by reset or by input hit_clear (1 bit, added).
- Undefined: neither port exists and there is no hit logic.

Decomposition:
- Package pixel_engine_pkg holds:
  - Default BPP and PIX_PER_WORD.
  - Typedefs pixel_t (logic [BPP-1:0]) and word_t.
  - Constant TRANSPARENT = '0.
  - Function flip_word (BPP-group reversal).
- Sub-module sprite_channel covers one sprite's buf/xcnt/rem/active/pri logic and emits visible and pixel. It is instantiated NUM_SPRITES times via generate.

Test Plan (defaults; WORD_W=32):
- Sprite 0: spr_x=3, data 32'h000000E4, bg zero; line_start then 8 pixel_en strobes -> pix_color 0,0,0,0,1,2,3,0; pix_is_sprite=1 only on strobes 5-7; pix_sprite_id=0.
- Same load with spr_flip=1 -> strobes 1-15 give colour 0; strobes 16,17,18 give 3,2,1; strobe 19 is transparent; channel inactive after strobe 19.
- Priority:
  - Sprites 2 and 5 at spr_x=0 with non-zero pixels -> id 2 wins.
  - Sprite 2 pri=1 with bg pixel 1 -> pix_color=1, pix_is_sprite=0. Sprite 5 is not shown.
- Background:
  - bg_load 32'hFFFFFFE4, line_start, fine_x=2 -> first outputs 2,3,3...
  - bg_need rises after line_start.
  - bg_load 32'h55555555 before strobe 14 -> strobes 15+ output 1; no underrun.
- Background underrun: no bg_load after line_start -> strobe 15+ output 0 and bg_underrun=1; next line_start clears it.
- Hazards:
  - spr_load with pixel_en on the same channel -> new word, no shift.
  - Reset mid-line -> next cycle all outputs 0, bg_need=1.
